// File: rtl/mesh_frame_driver_if.sv
// mesh_frame_driver_if: cell stream, mesh drive/capture and contour stream bundle (c_zeros present when MESH_CONTOUR_COUNT_EN is defined)
interface mesh_frame_driver_if #(
    parameter int COLS = 26,
    parameter int ROWS = 18
);
    logic                     s_valid;
    logic                     s_ready;
    logic [1:0]               s_data;
    logic [2*COLS*ROWS-1:0]   mesh_inp;
    logic                     mesh_high;
    logic [4*COLS*ROWS-1:0]   mesh_out;
    logic                     c_valid;
    logic                     c_ready;
    logic [COLS-1:0]          c_data;
    logic [4:0]               c_row;
    logic                     c_last;
`ifdef MESH_CONTOUR_COUNT_EN
    logic [4:0]               c_zeros;
    modport master (
        input  s_valid, s_data, mesh_out, c_ready,
        output s_ready, mesh_inp, mesh_high, c_valid, c_data, c_row, c_last, c_zeros
    );
    modport slave (
        output s_valid, s_data, mesh_out, c_ready,
        input  s_ready, mesh_inp, mesh_high, c_valid, c_data, c_row, c_last, c_zeros
    );
`else
    modport master (
        input  s_valid, s_data, mesh_out, c_ready,
        output s_ready, mesh_inp, mesh_high, c_valid, c_data, c_row, c_last
    );
    modport slave (
        output s_valid, s_data, mesh_out, c_ready,
        input  s_ready, mesh_inp, mesh_high, c_valid, c_data, c_row, c_last
    );
`endif
endinterface

// File: rtl/mesh_frame_driver.sv
// mesh_frame_driver: loads a 2-bit cell frame into the mesh, settles, captures and streams the east/west contour per row; MESH_CONTOUR_COUNT_EN adds c_zeros
module mesh_frame_driver #(
    parameter int COLS          = 26,
    parameter int ROWS          = 18,
    parameter int SETTLE_CYCLES = 4
) (
    input logic               clk,
    input logic               rst_n,
    mesh_frame_driver_if.master bus
);
    localparam int CELLS = COLS * ROWS;
    localparam int CW    = $clog2(CELLS + SETTLE_CYCLES);
    localparam int RW    = 4 * COLS;

    typedef enum logic [1:0] {LOAD, SETTLE, CAPTURE, EMIT} state_t;

    state_t              state, state_d;
    logic [CW-1:0]       cnt;
    logic [2*CELLS-1:0]  inp_q;
    logic [4*CELLS-1:0]  cap;
    logic [COLS-1:0]     data_q;
    logic [COLS-1:0]     row_contour;
    logic [4:0]          row_q;
    logic [4:0]          nrow;
    logic                last_q;
    logic                row_ld;
    logic [RW-1:0]       row_src;

    function automatic logic [COLS-1:0] contour(input logic [RW-1:0] r);
        logic [COLS-1:0] f;
        logic [COLS-1:0] o;
        for (int c = 0; c < COLS; c++) f[c] = &r[4*c +: 4];
        for (int c = 0; c < COLS; c++) o[c] = f[c] | (~f[(c+COLS-1)%COLS] & ~f[(c+1)%COLS]);
        return o;
    endfunction

    // The first row is taken straight from mesh_out during CAPTURE so it is valid on the first EMIT cycle
    assign nrow        = row_q + 5'd1;
    assign row_src     = (state == CAPTURE) ? bus.mesh_out[RW-1:0] : cap[nrow*RW +: RW];
    assign row_contour = contour(row_src);
    assign row_ld      = (state == CAPTURE) || (state == EMIT && bus.c_ready && !last_q);

    assign bus.mesh_inp = inp_q;
    assign bus.c_data   = data_q;
    assign bus.c_row    = row_q;
    assign bus.c_last   = last_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_d;
    end

    // Next-state and handshake outputs decoded from the current state
    always_comb begin
        state_d       = state;
        bus.s_ready   = state == LOAD;
        bus.mesh_high = state == SETTLE || state == CAPTURE;
        bus.c_valid   = state == EMIT;
        case (state)
            LOAD:    state_d = (bus.s_valid && cnt == CW'(CELLS-1)) ? SETTLE : LOAD;
            SETTLE:  state_d = (cnt == CW'(SETTLE_CYCLES-1)) ? CAPTURE : SETTLE;
            CAPTURE: state_d = EMIT;
            default: state_d = (bus.c_ready && last_q) ? LOAD : EMIT;
        endcase
    end

    // Frame assembly, settle counting, mesh capture and contour row registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            inp_q  <= '0;
            cap    <= '0;
            data_q <= '0;
            row_q  <= '0;
            last_q <= 1'b0;
        end else begin
            case (state)
                LOAD: if (bus.s_valid) begin
                    inp_q[2*cnt +: 2] <= bus.s_data;
                    cnt               <= (cnt == CW'(CELLS-1)) ? '0 : cnt + 1'b1;
                end
                SETTLE:  cnt <= (cnt == CW'(SETTLE_CYCLES-1)) ? '0 : cnt + 1'b1;
                CAPTURE: begin
                    cap   <= bus.mesh_out;
                    inp_q <= '0;
                end
                default: ;
            endcase
            if (row_ld) begin
                data_q <= row_contour;
                row_q  <= (state == CAPTURE) ? 5'd0 : nrow;
                last_q <= (state == CAPTURE) ? (ROWS == 1) : (nrow == 5'(ROWS-1));
            end
        end
    end

`ifdef MESH_CONTOUR_COUNT_EN
    function automatic logic [4:0] zeros(input logic [COLS-1:0] v);
        logic [4:0] z;
        z = '0;
        for (int c = 0; c < COLS; c++) z = z + {4'd0, ~v[c]};
        return z;
    endfunction

    logic [4:0] zeros_q;
    assign bus.c_zeros = zeros_q;

    // Zero count of the contour row, loaded together with c_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      zeros_q <= '0;
        else if (row_ld) zeros_q <= zeros(row_contour);
    end
`endif
endmodule

// File: tb/tb_mesh_frame_driver.sv
// tb_mesh_frame_driver: directed checks of frame load, settle/capture timing, contour rows, backpressure and mid-frame reset
module tb_mesh_frame_driver;
    localparam int COLS  = 26;
    localparam int ROWS  = 18;
    localparam int CELLS = COLS * ROWS;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mesh_frame_driver_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

    mesh_frame_driver #(.COLS(COLS), .ROWS(ROWS), .SETTLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    logic [2*CELLS-1:0] exp_inp;
    logic [COLS-1:0]    obs_data  [ROWS];
    logic [4:0]         obs_row   [ROWS];
    logic               obs_last  [ROWS];
    logic [4:0]         obs_zeros [ROWS];
    bit                 timeout, bp_ok, saw_valid, inp_ok;
    int                 hi, lat;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cell(input logic [1:0] d);
        int t;
        t = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (!bus.s_ready && t < 100) begin tick(); t++; end
        if (!bus.s_ready) timeout = 1'b1;
        if (bus.c_valid) saw_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic load_frame(input logic [1:0] first);
        for (int i = 0; i < CELLS; i++) exp_inp[2*i +: 2] = (i == 0) ? first : 2'b01;
        for (int i = 0; i < CELLS; i++) send_cell(exp_inp[2*i +: 2]);
    endtask

    // Counts mesh_high cycles and cycles from the accept cycle to c_valid; s_valid is held high to show it is ignored
    task automatic settle_phase();
        hi = 0;
        lat = 1;
        inp_ok = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 2'b11;
        while (!bus.c_valid && lat < 50) begin
            if (bus.mesh_high) hi++;
            if (bus.mesh_high && (bus.mesh_inp !== exp_inp || bus.s_ready !== 1'b0)) inp_ok = 1'b0;
            lat++;
            tick();
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic collect_rows(input int bp_row);
        timeout = 1'b0;
        bp_ok = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            int t;
            t = 0;
            while (!bus.c_valid && t < 50) begin tick(); t++; end
            if (!bus.c_valid) begin timeout = 1'b1; return; end
            obs_data[r] = bus.c_data;
            obs_row[r]  = bus.c_row;
            obs_last[r] = bus.c_last;
`ifdef MESH_CONTOUR_COUNT_EN
            obs_zeros[r] = bus.c_zeros;
`else
            obs_zeros[r] = 5'd0;
`endif
            if (r == bp_row) begin
                for (int k = 0; k < 5; k++) begin
                    tick();
                    if (!(bus.c_valid === 1'b1 && bus.c_data === obs_data[r] && bus.c_row === 5'(r) && bus.s_ready === 1'b0)) bp_ok = 1'b0;
                end
            end
            bus.c_ready = 1'b1;
            tick();
            bus.c_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.s_ready !== 1'b1 || bus.c_valid !== 1'b0 || bus.mesh_high !== 1'b0 || bus.mesh_inp !== '0 ||
            bus.c_data !== '0 || bus.c_row !== 5'd0 || bus.c_last !== 1'b0) begin
            failures++;
            $display("FAIL reset: s_ready=%b c_valid=%b mesh_high=%b mesh_inp_nz=%b c_data=%h c_row=%0d c_last=%b required 1 0 0 0 0 0 0",
                     bus.s_ready, bus.c_valid, bus.mesh_high, |bus.mesh_inp, bus.c_data, bus.c_row, bus.c_last);
        end
        #10 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_all_full();
        bus.mesh_out = '1;
        load_frame(2'b10);
        checks++;
        if (bus.mesh_inp[3:0] !== 4'b0110 || bus.mesh_high !== 1'b1) begin
            failures++;
            $display("FAIL all_full_inp: mesh_inp[3:0]=%b mesh_high=%b required 0110 1", bus.mesh_inp[3:0], bus.mesh_high);
        end
        settle_phase();
        checks++;
        if (hi !== 5) begin failures++; $display("FAIL all_full_high_cycles: got %0d required 5", hi); end
        checks++;
        if (lat !== 6) begin failures++; $display("FAIL all_full_latency: got %0d required 6", lat); end
        checks++;
        if (!inp_ok) begin failures++; $display("FAIL all_full_hold: mesh_inp/s_ready changed during settle, required held frame and s_ready=0"); end
        checks++;
        if (bus.mesh_inp !== '0 || bus.mesh_high !== 1'b0) begin
            failures++;
            $display("FAIL all_full_emit: mesh_inp_nz=%b mesh_high=%b required 0 0", |bus.mesh_inp, bus.mesh_high);
        end
        collect_rows(-1);
        checks++;
        if (timeout) begin failures++; $display("FAIL all_full_timeout: rows stopped early, required %0d rows", ROWS); end
        for (int r = 0; r < ROWS; r++) begin
            checks++;
            if (obs_data[r] !== 26'h3FFFFFF || obs_row[r] !== 5'(r) || obs_last[r] !== (r == ROWS-1)) begin
                failures++;
                $display("FAIL all_full_row%0d: data=%h row=%0d last=%b required 3ffffff %0d %b", r, obs_data[r], obs_row[r], obs_last[r], r, r == ROWS-1);
            end
        end
        checks++;
        if (bus.s_ready !== 1'b1 || bus.c_valid !== 1'b0) begin
            failures++;
            $display("FAIL all_full_back_to_load: s_ready=%b c_valid=%b required 1 0", bus.s_ready, bus.c_valid);
        end
    endtask

    task automatic test_single_full();
        bus.mesh_out = '0;
        bus.mesh_out[4*5 +: 4] = 4'hF;
        load_frame(2'b01);
        settle_phase();
        collect_rows(-1);
        checks++;
        if (timeout) begin failures++; $display("FAIL single_timeout: rows stopped early, required %0d rows", ROWS); end
        for (int r = 0; r < ROWS; r++) begin
            logic [COLS-1:0] e;
            e = (r == 0) ? 26'h3FFFFAF : 26'h3FFFFFF;
            checks++;
            if (obs_data[r] !== e || obs_row[r] !== 5'(r) || obs_last[r] !== (r == ROWS-1)) begin
                failures++;
                $display("FAIL single_row%0d: data=%h row=%0d last=%b required %h %0d %b", r, obs_data[r], obs_row[r], obs_last[r], e, r, r == ROWS-1);
            end
        end
`ifdef MESH_CONTOUR_COUNT_EN
        checks++;
        if (obs_zeros[0] !== 5'd2 || obs_zeros[1] !== 5'd0) begin
            failures++;
            $display("FAIL single_zeros: row0=%0d row1=%0d required 2 0", obs_zeros[0], obs_zeros[1]);
        end
`endif
    endtask

    task automatic test_wrap();
        bus.mesh_out = '0;
        bus.mesh_out[4*(2*COLS) +: 4] = 4'hF;
        load_frame(2'b11);
        settle_phase();
        collect_rows(-1);
        checks++;
        if (timeout) begin failures++; $display("FAIL wrap_timeout: rows stopped early, required %0d rows", ROWS); end
        for (int r = 0; r < ROWS; r++) begin
            logic [COLS-1:0] e;
            e = (r == 2) ? 26'h1FFFFFD : 26'h3FFFFFF;
            checks++;
            if (obs_data[r] !== e || obs_row[r] !== 5'(r)) begin
                failures++;
                $display("FAIL wrap_row%0d: data=%h row=%0d required %h %0d", r, obs_data[r], obs_row[r], e, r);
            end
        end
    endtask

    task automatic test_not_full();
        bus.mesh_out = '0;
        bus.mesh_out[4*(4*COLS+10) +: 4] = 4'hE;
        bus.mesh_out[4*(4*COLS+11) +: 4] = 4'hF;
        load_frame(2'b00);
        settle_phase();
        collect_rows(-1);
        checks++;
        if (timeout) begin failures++; $display("FAIL not_full_timeout: rows stopped early, required %0d rows", ROWS); end
        for (int r = 0; r < ROWS; r++) begin
            logic [COLS-1:0] e;
            e = (r == 4) ? 26'h3FFEBFF : 26'h3FFFFFF;
            checks++;
            if (obs_data[r] !== e || obs_row[r] !== 5'(r)) begin
                failures++;
                $display("FAIL not_full_row%0d: data=%h row=%0d required %h %0d", r, obs_data[r], obs_row[r], e, r);
            end
        end
    endtask

    task automatic test_backpressure();
        bus.mesh_out = '0;
        bus.mesh_out[4*(3*COLS+7) +: 4] = 4'hF;
        load_frame(2'b10);
        settle_phase();
        collect_rows(3);
        checks++;
        if (timeout) begin failures++; $display("FAIL bp_timeout: rows stopped early, required %0d rows", ROWS); end
        checks++;
        if (!bp_ok) begin failures++; $display("FAIL bp_stable: row 3 output moved while c_ready low, required c_valid=1 stable data row=3 s_ready=0"); end
        for (int r = 0; r < ROWS; r++) begin
            logic [COLS-1:0] e;
            e = (r == 3) ? 26'h3FFFEBF : 26'h3FFFFFF;
            checks++;
            if (obs_data[r] !== e || obs_row[r] !== 5'(r) || obs_last[r] !== (r == ROWS-1)) begin
                failures++;
                $display("FAIL bp_row%0d: data=%h row=%0d last=%b required %h %0d %b", r, obs_data[r], obs_row[r], obs_last[r], e, r, r == ROWS-1);
            end
        end
    endtask

    task automatic test_reset_midframe();
        bus.mesh_out = '0;
        bus.mesh_out[4*(2*COLS) +: 4] = 4'hF;
        saw_valid = 1'b0;
        for (int i = 0; i < 100; i++) send_cell(2'b11);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.s_ready !== 1'b1 || bus.mesh_inp !== '0 || bus.mesh_high !== 1'b0) begin
            failures++;
            $display("FAIL midreset: s_ready=%b mesh_inp_nz=%b mesh_high=%b required 1 0 0", bus.s_ready, |bus.mesh_inp, bus.mesh_high);
        end
        #2 rst_n = 1'b1;
        tick();
        load_frame(2'b10);
        settle_phase();
        checks++;
        if (!inp_ok || hi !== 5) begin failures++; $display("FAIL midreset_frame: inp_ok=%b high_cycles=%0d required 1 5", inp_ok, hi); end
        checks++;
        if (saw_valid) begin failures++; $display("FAIL midreset_early_rows: c_valid seen during load, required none"); end
        collect_rows(-1);
        checks++;
        if (timeout) begin failures++; $display("FAIL midreset_timeout: rows stopped early, required %0d rows", ROWS); end
        for (int r = 0; r < ROWS; r++) begin
            logic [COLS-1:0] e;
            e = (r == 2) ? 26'h1FFFFFD : 26'h3FFFFFF;
            checks++;
            if (obs_data[r] !== e || obs_row[r] !== 5'(r)) begin
                failures++;
                $display("FAIL midreset_row%0d: data=%h row=%0d required %h %0d", r, obs_data[r], obs_row[r], e, r);
            end
        end
    endtask

    initial begin
        bus.s_valid  = 1'b0;
        bus.s_data   = 2'b00;
        bus.c_ready  = 1'b0;
        bus.mesh_out = '0;
        timeout      = 1'b0;
        saw_valid    = 1'b0;
        test_reset();
        test_all_full();
        test_single_full();
        test_wrap();
        test_not_full();
        test_backpressure();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
